// File: rtl/hazard_stall_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_pkg
//  Description : Shared opcode constants, hazard FSM state type and source
//                register usage helpers for the hazard/forwarding path.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_pkg;

    // Opcodes (instr[15:11]) referenced by the hazard and forwarding logic
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_LBI  = 5'b11000;
    localparam logic [4:0] OP_SLBI = 5'b10010;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_STU  = 5'b10011;

    // Stall/flush controller states
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        FLUSH   = 2'd3
    } hs_state_t;

    // Every opcode except the ones with no register source reads Rs
    function automatic logic rs_used(input logic [4:0] op);
        return !(op inside {OP_HALT, OP_NOP, OP_J, OP_JAL, OP_LBI});
    endfunction

    // Register-register ALU/compare formats and stores also read Rt
    function automatic logic rt_used(input logic [4:0] op);
        return op inside {5'b11011, 5'b11010, 5'b11100, 5'b11101,
                          5'b11110, 5'b11111, OP_ST, OP_STU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_decode.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_src_decode
//  Description : Combinational decode of which source registers the
//                instruction in ID actually reads, plus their indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_src_decode
    import hazard_stall_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic        o_rs_used,
    output logic        o_rt_used,
    output logic [2:0]  o_rs,
    output logic [2:0]  o_rt
);

    // Immediate/function bits are irrelevant for hazard detection
    logic w_unused_bits;
    assign w_unused_bits = ^i_instr[4:0];

    // Source usage comes from the opcode; indices are fixed fields
    always_comb begin
        o_rs_used = rs_used(i_instr[15:11]);
        o_rt_used = rt_used(i_instr[15:11]);
        o_rs      = i_instr[10:8];
        o_rt      = i_instr[7:5];
    end

endmodule
`default_nettype wire

// File: rtl/hazard_stall.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall
//  Description : Decode-side stall/flush controller. Resolves load-use,
//                data-memory-busy and taken-branch hazards by driving PC and
//                IF/ID hold, ID/EX bubble, IF/ID flush and pipe freeze.
//                Optional build macro STALL_PERF_CNT_EN adds saturating
//                stall_count / flush_count performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall
    import hazard_stall_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,    // IF/ID squash cycles after redirect (1..7)
    parameter int MEM_TIMEOUT  = 255   // busy cycles before mem_timeout
)(
    input  logic        clk,
    input  logic        rst,           // asynchronous, active-low
    input  logic [15:0] instr_dec,
    input  logic [15:0] instr_ex,
    input  logic        ex_regWriteEn,
    input  logic [2:0]  ex_dst,
    input  logic        mem_busy,
    input  logic        branch_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        pipe_freeze,
    output logic        mem_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    localparam logic [2:0] c_fcnt_load = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] c_timeout   = 8'(MEM_TIMEOUT);

    hs_state_t   state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        tout_q, tout_d;

    logic        w_rs_used, w_rt_used;
    logic [2:0]  w_rs, w_rt;
    logic        w_load_use;
    logic        w_stall, w_bubble, w_flush, w_freeze;
    logic        w_wcnt_wr;
    logic        w_tout_hit;
    logic        w_unused_ex;

    // Only the EX opcode matters here; register fields arrive via ex_dst
    assign w_unused_ex = ^instr_ex[10:0];

    hazard_src_decode u_src_decode (
        .i_instr   (instr_dec),
        .o_rs_used (w_rs_used),
        .o_rt_used (w_rt_used),
        .o_rs      (w_rs),
        .o_rt      (w_rt)
    );

    // Load in EX whose destination feeds a source the ID instruction reads
    always_comb begin
        w_load_use = (instr_ex[15:11] == OP_LD) & ex_regWriteEn &
                     ((w_rs_used & (ex_dst == w_rs)) |
                      (w_rt_used & (ex_dst == w_rt)));
    end

    // Next-state, counter and raw control outputs; branch > mem_busy > load-use
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        wcnt_d    = wcnt_q;
        w_wcnt_wr = 1'b0;
        w_stall   = 1'b0;
        w_bubble  = 1'b0;
        w_flush   = 1'b0;
        w_freeze  = 1'b0;
        case (state_q)
            RUN, LDSTALL: begin
                if (branch_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        fcnt_d  = c_fcnt_load;
                        state_d = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end else if (mem_busy) begin
                    w_freeze  = 1'b1;
                    w_stall   = 1'b1;
                    wcnt_d    = 8'd1;
                    w_wcnt_wr = 1'b1;
                    state_d   = MEMWAIT;
                end else if (w_load_use && (state_q == RUN)) begin
                    // LDSTALL never re-stalls, so one load costs one bubble
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    state_d  = LDSTALL;
                end else begin
                    state_d = RUN;
                end
            end
            MEMWAIT: begin
                // EX is held while frozen, so a branch here re-presents later
                if (mem_busy) begin
                    w_freeze  = 1'b1;
                    w_stall   = 1'b1;
                    w_wcnt_wr = 1'b1;
                    if (wcnt_q != 8'hFF) begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
                if (branch_taken) begin
                    fcnt_d = c_fcnt_load;
                    if (FLUSH_CYCLES <= 1) begin
                        state_d = RUN;
                    end
                end else if (mem_busy) begin
                    // Freeze pauses the squash window without consuming it
                    w_freeze = 1'b1;
                    w_stall  = 1'b1;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q <= 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        w_tout_hit = w_wcnt_wr & (wcnt_d == c_timeout);
        tout_d     = tout_q | w_tout_hit;
    end

    // Controller state and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= 3'd0;
            wcnt_q  <= 8'd0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            tout_q  <= tout_d;
        end
    end

    // Outputs are forced low for as long as reset is held
    always_comb begin
        pc_stall    = rst & w_stall;
        ifid_stall  = rst & w_stall;
        idex_bubble = rst & w_bubble;
        ifid_flush  = rst & w_flush;
        pipe_freeze = rst & w_freeze;
        mem_timeout = rst & (tout_q | w_tout_hit);
    end

`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating event counters for stalled and squashed cycles
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (pc_stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (ifid_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall
//  Description : Self-checking bench for hazard_stall: directed scenarios plus
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall;

    localparam int FC = 2;
    localparam int MT = 8;

    localparam logic [15:0] LD_R3   = 16'b10001_000_011_00000;
    localparam logic [15:0] ADD_RS3 = 16'b11011_011_001_010_00;
    localparam logic [15:0] LBI_R3  = 16'b11000_011_00000000;
    localparam logic [15:0] ST_RT3  = 16'b10000_001_011_00000;
    localparam logic [15:0] NOP_I   = 16'b00001_000_000_00000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_dec = NOP_I;
    logic [15:0] instr_ex  = NOP_I;
    logic        ex_regWriteEn = 1'b0;
    logic [2:0]  ex_dst = 3'd0;
    logic        mem_busy = 1'b0;
    logic        branch_taken = 1'b0;
    logic        pc_stall, ifid_stall, idex_bubble, ifid_flush, pipe_freeze, mem_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_count, flush_count;
`endif

    // {pc_stall, ifid_stall, idex_bubble, ifid_flush, pipe_freeze, mem_timeout}
    logic [5:0] obs;
    assign obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, pipe_freeze, mem_timeout};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_stall #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_dec     (instr_dec),
        .instr_ex      (instr_ex),
        .ex_regWriteEn (ex_regWriteEn),
        .ex_dst        (ex_dst),
        .mem_busy      (mem_busy),
        .branch_taken  (branch_taken),
        .pc_stall      (pc_stall),
        .ifid_stall    (ifid_stall),
        .idex_bubble   (idex_bubble),
        .ifid_flush    (ifid_flush),
        .pipe_freeze   (pipe_freeze),
        .mem_timeout   (mem_timeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_count   (stall_count),
        .flush_count   (flush_count)
`endif
    );

    task automatic drive(input logic [15:0] d, input logic [15:0] e, input logic we,
                         input logic [2:0] dst, input logic mb, input logic br);
        instr_dec     = d;
        instr_ex      = e;
        ex_regWriteEn = we;
        ex_dst        = dst;
        mem_busy      = mb;
        branch_taken  = br;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Spec-level load-use rule, written from the opcode lists directly
    function automatic bit ref_lu(input logic [15:0] d, input logic [15:0] e,
                                  input logic we, input logic [2:0] dst);
        logic [4:0] op;
        bit rsu, rtu;
        op  = d[15:11];
        rsu = !(op inside {5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11000});
        rtu = op inside {5'b11011, 5'b11010, 5'b11100, 5'b11101,
                         5'b11110, 5'b11111, 5'b10000, 5'b10011};
        return (e[15:11] == 5'b10001) && we &&
               ((rsu && dst == d[10:8]) || (rtu && dst == d[7:5]));
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        drive(ADD_RS3, LD_R3, 1'b1, 3'd3, 1'b1, 1'b1);
        #3;
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=%b", obs, 6'b0);
        end
        drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle got=%b want=%b", obs, 6'b0);
        end
        next_cycle();
    endtask

    task automatic test_load_use;
        drive(ADD_RS3, LD_R3, 1'b1, 3'd3, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            logic [5:0] want;
            if (c == 2) drive(ADD_RS3, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
            want = (c == 0) ? 6'b111000 : 6'b000000;
            @(negedge clk);
            n_tests++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL load_use_cycle%0d got=%b want=%b", c, obs, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_no_dependency;
        logic [15:0] dec_t [4] = '{LBI_R3, ADD_RS3, ST_RT3, ADD_RS3};
        logic [2:0]  dst_t [4] = '{3'd3, 3'd4, 3'd3, 3'd3};
        logic        we_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [5:0]  exp_t [4] = '{6'b000000, 6'b000000, 6'b111000, 6'b000000};
        for (int i = 0; i < 4; i++) begin
            drive(dec_t[i], LD_R3, we_t[i], dst_t[i], 1'b0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (obs !== exp_t[i]) begin
                n_fail++;
                $display("FAIL no_dep_case%0d got=%b want=%b", i, obs, exp_t[i]);
            end
            next_cycle();
            drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic test_branch_flush;
        // single pulse, then a re-pulse inside the squash window
        logic       br_t  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0] exp_t [7] = '{6'b001100, 6'b001100, 6'b000000,
                                  6'b001100, 6'b001100, 6'b001100, 6'b000000};
        for (int i = 0; i < 7; i++) begin
            drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, br_t[i]);
            @(negedge clk);
            n_tests++;
            if (obs !== exp_t[i]) begin
                n_fail++;
                $display("FAIL branch_flush_cycle%0d got=%b want=%b", i, obs, exp_t[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_priority;
        logic       br_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       mb_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0] exp_t [5] = '{6'b001100, 6'b111110, 6'b111110, 6'b001100, 6'b000000};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(ADD_RS3, LD_R3, 1'b1, 3'd3, mb_t[i], br_t[i]);
            else       drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (obs !== exp_t[i]) begin
                n_fail++;
                $display("FAIL priority_cycle%0d got=%b want=%b", i, obs, exp_t[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait;
        logic [5:0] want;
        for (int i = 1; i <= 6; i++) begin
            drive(NOP_I, NOP_I, 1'b0, 3'd0, (i <= 5), 1'b0);
            want = (i <= 5) ? 6'b110010 : 6'b000000;
            @(negedge clk);
            n_tests++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL mem_wait_short%0d got=%b want=%b", i, obs, want);
            end
            next_cycle();
        end
        for (int k = 1; k <= 12; k++) begin
            drive(NOP_I, NOP_I, 1'b0, 3'd0, (k <= 10), 1'b0);
            want = (k <= 10) ? {5'b11001, (k >= MT)} : 6'b000001;
            @(negedge clk);
            n_tests++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL mem_timeout_cycle%0d got=%b want=%b", k, obs, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset;
        drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (obs !== 6'b110011) begin
            n_fail++;
            $display("FAIL async_pre got=%b want=%b", obs, 6'b110011);
        end
        next_cycle();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL async_assert got=%b want=%b", obs, 6'b0);
        end
        drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        drive(ADD_RS3, LD_R3, 1'b1, 3'd3, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (obs !== 6'b111000) begin
            n_fail++;
            $display("FAIL async_run_after got=%b want=%b", obs, 6'b111000);
        end
        next_cycle();
        drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_random;
        int  flush_left = 0;
        bit  frozen     = 1'b0;
        int  busy_run   = 0;
        bit  timed_out  = 1'b0;
        bit  ld_prev    = 1'b0;
        bit  prev_mb    = 1'b0;
        int  stall_cyc  = 0;
        int  flush_cyc  = 0;
        rst = 1'b0;
        drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r1, r2;
            logic [4:0]  op;
            logic [15:0] d, e;
            logic [2:0]  dst;
            logic        we, mb, br;
            bit          ld_now;
            logic [5:0]  want;
            r1  = $urandom();
            r2  = $urandom();
            op  = ($urandom_range(0, 2) != 0) ? 5'b10001 : r1[31:27];
            e   = {op, r1[10:0]};
            d   = r2[15:0];
            dst = ($urandom_range(0, 1) == 1) ? d[10:8] : r2[18:16];
            we  = ($urandom_range(0, 3) != 0);
            mb  = ($urandom_range(0, 99) < (prev_mb ? 85 : 12));
            br  = ($urandom_range(0, 9) == 0);
            prev_mb = mb;
            drive(d, e, we, dst, mb, br);

            want   = 6'b0;
            ld_now = 1'b0;
            if (frozen) begin
                if (mb) begin
                    want     = 6'b110010;
                    busy_run = (busy_run < 255) ? busy_run + 1 : 255;
                    if (busy_run >= MT) timed_out = 1'b1;
                end else begin
                    frozen = 1'b0;
                end
            end else if (flush_left > 0) begin
                want = 6'b001100;
                if (br)      flush_left = FC - 1;
                else if (mb) want = 6'b111110;
                else         flush_left--;
            end else if (br) begin
                want       = 6'b001100;
                flush_left = FC - 1;
            end else if (mb) begin
                want     = 6'b110010;
                frozen   = 1'b1;
                busy_run = 1;
                if (busy_run >= MT) timed_out = 1'b1;
            end else if (ref_lu(d, e, we, dst) && !ld_prev) begin
                want   = 6'b111000;
                ld_now = 1'b1;
            end
            ld_prev = ld_now;
            want[0] = timed_out;
            if (want[5]) stall_cyc++;
            if (want[2]) flush_cyc++;

            @(negedge clk);
            n_tests++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL random_cycle%0d got=%b want=%b (dec=%h ex=%h we=%b dst=%0d mb=%b br=%b)",
                         n, obs, want, d, e, we, dst, mb, br);
            end
            next_cycle();
        end
`ifdef STALL_PERF_CNT_EN
        n_tests++;
        if (stall_count !== 16'(stall_cyc)) begin
            n_fail++;
            $display("FAIL stall_count got=%0d want=%0d", stall_count, stall_cyc);
        end
        n_tests++;
        if (flush_count !== 16'(flush_cyc)) begin
            n_fail++;
            $display("FAIL flush_count got=%0d want=%0d", flush_count, flush_cyc);
        end
`endif
        drive(NOP_I, NOP_I, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_dependency();
        test_branch_flush();
        test_priority();
        test_mem_wait();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
